// File: rtl/instr_fetch.sv
// RV32 instruction fetch stage: PC ownership, imem req/ack fetch, one-entry prefetch buffer.
// Optional misaligned-redirect trap is compiled in with FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        fetch_fault
);

  // Handshakes: imem_req/imem_addr stay stable from rise until the cycle imem_ack
  // is high; decode takes instr on any cycle where instr_valid & instr_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        fault_q, fault_d;

  logic        ack_v;
  logic        accept;
  logic [31:0] target;
  logic        target_bad;
  logic        outstanding;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = pc_target;
  assign target_bad = |pc_target[1:0];
`else
  assign target     = pc_target & 32'hFFFF_FFFC;
  assign target_bad = 1'b0;
`endif

  // Acks that arrive with no request raised (e.g. just after reset) are stray.
  assign ack_v       = imem_ack & req_q;
  assign accept      = (state_q == S_VALID) & instr_ready;
  assign outstanding = req_q & ~ack_v;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_pc_d    = buf_pc_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE: begin
        if (!fault_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ack_v) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (accept && pc_src) begin
          buf_valid_d = 1'b0;
          if (target_bad) begin
            fault_d = 1'b1;
            state_d = outstanding ? S_DROP : S_IDLE;
          end else begin
            pc_d    = target;
            state_d = outstanding ? S_DROP : S_FETCH;
          end
        end else if (accept) begin
          if (buf_valid_q) begin
            instr_d     = buf_data_q;
            instr_pc_d  = buf_pc_q;
            buf_valid_d = 1'b0;
          end else if (ack_v) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end else begin
            state_d = S_FETCH;
          end
        end else if (ack_v) begin
          buf_valid_d = 1'b1;
          buf_data_d  = imem_rdata;
          buf_pc_d    = pc_q;
          pc_d        = pc_q + 32'd4;
        end
      end
      S_DROP: begin
        if (ack_v) state_d = fault_q ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // DROP keeps the stale address on the bus while pc already holds the target.
    req_d  = (state_d == S_FETCH) || (state_d == S_DROP) ||
             ((state_d == S_VALID) && !buf_valid_d);
    addr_d = (state_d == S_DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      instr_q     <= NOP;
      instr_pc_q  <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_data_q  <= NOP;
      buf_pc_q    <= RESET_PC;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_pc_q    <= buf_pc_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign instr_valid    = (state_q == S_VALID);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_q + 32'd4;
  assign opcode         = instr_q[6:0];
  assign funct3         = instr_q[14:12];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_q;
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirects, DROP,
// PC wrap, reset during DROP, and misaligned targets (FETCH_MISALIGN_TRAP_EN aware).
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  // Memory model: ack after ws wait cycles of a raised request; force_ack injects strays.
  int   ws = 0;
  int   cnt = 0;
  logic force_ack = 1'b0;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus4(instr_pc_plus4),
    .opcode        (opcode),
    .funct3        (funct3),
    .fetch_fault   (fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[27:0], 4'h3};
  endfunction

  assign imem_ack   = (imem_req && (cnt >= ws)) || force_ack;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    pc_src = 1'b0;
    pc_target = 32'h0;
    instr_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    // reset values
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_instr_pc", instr_pc, 32'h100);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_plus4", instr_pc_plus4, 32'h104);
    chk("rst_opcode", {25'b0, opcode}, 32'h13);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // streaming from zero-wait memory
    rst_n = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    chk("first_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("s0_valid", {31'b0, instr_valid}, 32'd1);
    chk("s0_pc", instr_pc, 32'h100);
    chk("s0_instr", instr, 32'h0000_1003);
    chk("s0_addr", imem_addr, 32'h104);
    tick();
    chk("s1_pc", instr_pc, 32'h104);
    chk("s1_addr", imem_addr, 32'h108);
    chk("s1_funct3", {29'b0, funct3}, 32'd1);

    // backpressure: 0x108 is prefetched into the buffer, then req drops
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_pc", instr_pc, 32'h104);
      chk("bp_instr", instr, 32'h0000_1043);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_rel_pc", instr_pc, 32'h108);
    chk("bp_rel_instr", instr, 32'h0000_1083);
    chk("bp_rel_req", {31'b0, imem_req}, 32'd1);
    chk("bp_rel_addr", imem_addr, 32'h10C);

    // redirect with zero-wait memory: one bubble then target
    pc_src = 1'b1;
    pc_target = 32'h200;
    tick();
    pc_src = 1'b0;
    chk("rd_bubble", {31'b0, instr_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h200);
    tick();
    chk("rd_valid", {31'b0, instr_valid}, 32'd1);
    chk("rd_pc", instr_pc, 32'h200);
    chk("rd_instr", instr, 32'h0000_2003);

    // redirect while the buffer is full: buffered 0x204 must never appear
    instr_ready = 1'b0;
    tick();
    chk("rb_req", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    pc_src = 1'b1;
    pc_target = 32'h300;
    tick();
    pc_src = 1'b0;
    chk("rb_bubble", {31'b0, instr_valid}, 32'd0);
    chk("rb_addr", imem_addr, 32'h300);
    tick();
    chk("rb_pc", instr_pc, 32'h300);
    chk("rb_funct3", {29'b0, funct3}, 32'd3);

    // 3-cycle memory: redirect while 0x304 is outstanding -> DROP
    ws = 2;
    pc_src = 1'b1;
    pc_target = 32'h200;
    tick();
    pc_src = 1'b0;
    chk("dr_valid", {31'b0, instr_valid}, 32'd0);
    chk("dr_addr0", imem_addr, 32'h304);
    chk("dr_req0", {31'b0, imem_req}, 32'd1);
    tick();
    chk("dr_addr1", imem_addr, 32'h304);
    tick();
    chk("dr_new_addr", imem_addr, 32'h200);
    chk("dr_new_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    tick();
    chk("dr_wait_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("dr_valid_end", {31'b0, instr_valid}, 32'd1);
    chk("dr_pc", instr_pc, 32'h200);
    chk("dr_instr", instr, 32'h0000_2003);

    // wrap at top of address space
    ws = 0;
    pc_src = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_plus4", instr_pc_plus4, 32'h0);
    chk("wr_next_addr", imem_addr, 32'h0);
    chk("wr_instr", instr, 32'hFFFF_FFC3);

    // enter DROP on a stalled fetch, then reset asynchronously
    ws = 100;
    pc_src = 1'b1;
    pc_target = 32'h500;
    tick();
    pc_src = 1'b0;
    chk("rs_drop_addr", imem_addr, 32'h0);
    chk("rs_drop_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_req", {31'b0, imem_req}, 32'd0);
    chk("rs_addr", imem_addr, 32'h100);
    chk("rs_pc", instr_pc, 32'h100);
    chk("rs_instr", instr, 32'h0000_0013);
    chk("rs_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    // stray ack in IDLE right after release is ignored
    ws = 0;
    force_ack = 1'b1;
    rst_n = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("st_valid", {31'b0, instr_valid}, 32'd0);
    chk("st_instr", instr, 32'h0000_0013);
    chk("st_req", {31'b0, imem_req}, 32'd1);
    chk("st_addr", imem_addr, 32'h100);
    tick();
    chk("st_pc", instr_pc, 32'h100);
    chk("st_valid2", {31'b0, instr_valid}, 32'd1);

    // misaligned redirect target
    pc_src = 1'b1;
    pc_target = 32'h202;
    tick();
    pc_src = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_fault", {31'b0, fetch_fault}, 32'd1);
    chk("ma_req", {31'b0, imem_req}, 32'd0);
    chk("ma_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    tick();
    chk("ma_req_late", {31'b0, imem_req}, 32'd0);
    chk("ma_valid_late", {31'b0, instr_valid}, 32'd0);
`else
    chk("ma_fault", {31'b0, fetch_fault}, 32'd0);
    chk("ma_addr", imem_addr, 32'h200);
    chk("ma_req", {31'b0, imem_req}, 32'd1);
    tick();
    chk("ma_pc", instr_pc, 32'h200);
    chk("ma_valid", {31'b0, instr_valid}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
